// File: rtl/trig_input_conditioner.sv
`timescale 1ns/1ps
// Coax trigger front end: synchronise, mask and edge-detect the inputs, count per-channel rates
// per window and sticky-mask hot channels. Optional macro: INPUT_GLITCH_FILTER_EN.
module trig_input_conditioner #(
    parameter int NCH   = 64,
    parameter int CNT_W = 16,
    parameter int WIN_W = 24
) (
    input  logic             clk_adc,
    input  logic             nrst,
    input  logic [NCH-1:0]   coax_in,
    input  logic [NCH-1:0]   triggermask,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] hot_thresh,
    input  logic             clear_automask,
    input  logic [5:0]       rate_sel,
    output logic [NCH-1:0]   coax_hits,
    output logic [NCH-1:0]   auto_mask,
    output logic [31:0]      rate_out,
    output logic             window_done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0]   s1_r;
    logic [NCH-1:0]   s2_r;
    logic [NCH-1:0]   prev_r;
    logic [NCH-1:0]   lvl_s;
    logic [NCH-1:0]   edge_s;
    logic [NCH-1:0]   hot_s;
    logic [WIN_W-1:0] win_ctr_r;
    logic [WIN_W-1:0] win_last_s;
    logic             win_end_s;
    logic [CNT_W-1:0] cnt_r      [NCH];
    logic [CNT_W-1:0] rate_lat_r [NCH];

`ifdef INPUT_GLITCH_FILTER_EN
    logic [NCH-1:0]   s3_r;

    // Extra stage so a level qualifies only after two consecutive asserted samples.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            s3_r <= '0;
        end else begin
            s3_r <= s2_r;
        end
    end

    assign lvl_s = s2_r & s3_r;
`else
    assign lvl_s = s2_r;
`endif

    // Two-flop synchroniser on the inverted inputs, then level history for edge detection.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            s1_r   <= '0;
            s2_r   <= '0;
            prev_r <= '0;
        end else begin
            s1_r   <= ~coax_in;
            s2_r   <= s1_r;
            prev_r <= lvl_s;
        end
    end

    // Edge detect, window-end decode (tolerates win_len shrinking mid-window) and hot check.
    always_comb begin
        edge_s     = lvl_s & ~prev_r & triggermask;
        win_last_s = (win_len == WIN_ZERO) ? WIN_ZERO : (win_len - WIN_ONE);
        win_end_s  = (win_ctr_r >= win_last_s);
        hot_s      = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_end_s && (hot_thresh != CNT_ZERO) && (cnt_r[i] >= hot_thresh)) begin
                hot_s[i] = 1'b1;
            end else begin
                hot_s[i] = 1'b0;
            end
        end
    end

    // Free-running window counter and its end-of-window pulse.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            win_ctr_r   <= WIN_ZERO;
            window_done <= 1'b0;
        end else begin
            win_ctr_r   <= win_end_s ? WIN_ZERO : (win_ctr_r + WIN_ONE);
            window_done <= win_end_s;
        end
    end

    // Hit pulses and sticky auto-mask; a clear beats a same-cycle set.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            coax_hits <= '0;
            auto_mask <= '0;
        end else begin
            coax_hits <= edge_s & ~auto_mask;
            if (clear_automask) begin
                auto_mask <= '0;
            end else begin
                auto_mask <= auto_mask | hot_s;
            end
        end
    end

    // Saturating rate counters; a boundary edge seeds the new window with 1.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]      <= CNT_ZERO;
                rate_lat_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (win_end_s) begin
                    rate_lat_r[i] <= cnt_r[i];
                    cnt_r[i]      <= edge_s[i] ? CNT_ONE : CNT_ZERO;
                end else if (edge_s[i] && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Registered readout of the selected latched rate.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            rate_out <= 32'd0;
        end else begin
            rate_out <= {{(32-CNT_W){1'b0}}, rate_lat_r[rate_sel]};
        end
    end

endmodule

// File: tb/tb_trig_input_conditioner.sv
`timescale 1ns/1ps
// Bench for trig_input_conditioner: vector table checked through a hit scoreboard, then
// directed window, boundary, auto-mask, user-mask and reset sequences.
module tb_trig_input_conditioner;

`ifdef INPUT_GLITCH_FILTER_EN
    localparam int LAT       = 4;
    localparam int TBL_RATE5 = 2;
`else
    localparam int LAT       = 3;
    localparam int TBL_RATE5 = 3;
`endif

    logic        clk_adc = 1'b0;
    logic        nrst;
    logic [63:0] coax_in;
    logic [63:0] triggermask;
    logic [23:0] win_len;
    logic [15:0] hot_thresh;
    logic        clear_automask;
    logic [5:0]  rate_sel;
    logic [63:0] coax_hits;
    logic [63:0] auto_mask;
    logic [31:0] rate_out;
    logic        window_done;

    typedef struct {
        logic [63:0] low;
        logic [63:0] hits;
        logic [63:0] hits_f;
    } vec_t;

    typedef struct {
        int          due;
        logic [63:0] hits;
    } sb_t;

    vec_t        tbl [14];
    sb_t         sb [$];
    sb_t         e_mon;
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          h;
    int          pulses;
    logic [31:0] r;
    logic [63:0] any_hits;

    trig_input_conditioner dut (
        .clk_adc        (clk_adc),
        .nrst           (nrst),
        .coax_in        (coax_in),
        .triggermask    (triggermask),
        .win_len        (win_len),
        .hot_thresh     (hot_thresh),
        .clear_automask (clear_automask),
        .rate_sel       (rate_sel),
        .coax_hits      (coax_hits),
        .auto_mask      (auto_mask),
        .rate_out       (rate_out),
        .window_done    (window_done)
    );

    always #5 clk_adc = ~clk_adc;

    always @(posedge clk_adc) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop the expectation due on this cycle and compare the hit vector.
    always @(negedge clk_adc) begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
            e_mon = sb.pop_front();
            n_vec++;
            if (coax_hits !== e_mon.hits || e_mon.due != cyc) begin
                n_err++;
                $display("FAIL sb_hits cyc %0d: got %h, expected %h (due %0d)",
                         cyc, coax_hits, e_mon.hits, e_mon.due);
            end
        end
    end

    task automatic wait_window();
        int n = 0;
        do begin
            @(negedge clk_adc);
            n++;
        end while (!window_done && n < 5000);
        check("window_wait", {63'd0, window_done}, 64'd1);
    endtask

    // One 50-tick window: ch0 low pairs from j=1, optional boundary edge, optional clear pulse.
    task automatic run_window(input int npairs, input bit bnd, input int clr_j,
                              output int hits, output logic [31:0] r1);
        hits = 0;
        r1   = 32'd0;
        for (int j = 1; j <= 50; j++) begin
            @(posedge clk_adc);
            #1;
            coax_in[0]     = !(((j <= 4 * npairs) && ((j - 1) % 4 < 2)) ||
                               (bnd && (j == 50 - LAT || j == 51 - LAT)));
            clear_automask = (j == clr_j);
            @(negedge clk_adc);
            if (coax_hits[0]) hits++;
            if (j == 1) r1 = rate_out;
        end
        check("window_end", {63'd0, window_done}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{64'h0, 64'h0, 64'h0};
        tbl[1]  = '{64'h20, 64'h20, 64'h0};
        tbl[2]  = '{64'h20, 64'h0, 64'h20};
        tbl[3]  = '{64'h20, 64'h0, 64'h0};
        tbl[4]  = '{64'h0, 64'h0, 64'h0};
        tbl[5]  = '{64'h21, 64'h21, 64'h0};
        tbl[6]  = '{64'h01, 64'h0, 64'h01};
        tbl[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0};
        tbl[8]  = '{64'h8000_0000_0000_0002, 64'h2, 64'h8000_0000_0000_0000};
        tbl[9]  = '{64'h0, 64'h0, 64'h0};
        tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        tbl[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[12] = '{64'h0, 64'h0, 64'h0};
        tbl[13] = '{64'h0, 64'h0, 64'h0};

        nrst           = 1'b0;
        coax_in        = '1;
        triggermask    = '1;
        win_len        = 24'd1000;
        hot_thresh     = 16'd0;
        clear_automask = 1'b0;
        rate_sel       = 6'd0;
        #1;
        check("reset_hits", coax_hits, 64'd0);
        check("reset_amask", auto_mask, 64'd0);
        check("reset_rate", {32'd0, rate_out}, 64'd0);
        check("reset_wdone", {63'd0, window_done}, 64'd0);
        repeat (2) @(posedge clk_adc);
        #1 nrst = 1'b1;
        repeat (10) @(posedge clk_adc);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk_adc);
            #1;
            coax_in = ~tbl[i].low;
`ifdef INPUT_GLITCH_FILTER_EN
            sb.push_back('{cyc + LAT, tbl[i].hits_f});
`else
            sb.push_back('{cyc + LAT, tbl[i].hits});
`endif
        end
        @(posedge clk_adc);
        #1 coax_in = '1;
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk_adc);
        check("sb_drain", 64'(sb.size()), 64'd0);

        // User mask on ch5 plus a mid-window shrink of win_len.
        @(posedge clk_adc);
        #1;
        win_len        = 24'd20;
        rate_sel       = 6'd5;
        triggermask[5] = 1'b0;
        @(posedge clk_adc);
        @(negedge clk_adc);
        check("winlen_shrink", {63'd0, window_done}, 64'd1);
        any_hits = 64'd0;
        for (int j = 1; j <= 21; j++) begin
            @(posedge clk_adc);
            #1 coax_in[5] = !((j <= 20) && ((j - 1) % 4 < 2));
            @(negedge clk_adc);
            any_hits = any_hits | coax_hits;
            if (j == 1)  check("rate5_table", {32'd0, rate_out}, 64'(TBL_RATE5));
            if (j == 19) check("win20_not_yet", {63'd0, window_done}, 64'd0);
            if (j == 20) check("win20_end", {63'd0, window_done}, 64'd1);
            if (j == 21) check("rate5_masked", {32'd0, rate_out}, 64'd0);
        end
        check("mask_no_hits", any_hits, 64'd0);

        @(posedge clk_adc);
        #1 win_len = 24'd0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk_adc);
            @(negedge clk_adc);
            check("winlen_zero", {63'd0, window_done}, 64'd1);
        end

        @(posedge clk_adc);
        #1;
        win_len     = 24'd50;
        triggermask = '1;
        rate_sel    = 6'd0;
        wait_window();

        run_window(2, 1'b1, 0, h, r);
        check("bnd_hits", 64'(h), 64'd3);
        run_window(0, 1'b0, 0, h, r);
        check("bnd_prior_excl", {32'd0, r}, 64'd2);
        hot_thresh = 16'd5;
        run_window(6, 1'b0, 0, h, r);
        check("bnd_new_cnt", {32'd0, r}, 64'd1);
        check("am_hits", 64'(h), 64'd6);
        check("am_set", auto_mask, 64'h1);
        run_window(3, 1'b0, 0, h, r);
        check("am_suppressed", 64'(h), 64'd0);
        check("am_prev_rate", {32'd0, r}, 64'd6);
        run_window(1, 1'b0, 1, h, r);
        check("am_still_counted", {32'd0, r}, 64'd3);
        check("clear_hits", 64'(h), 64'd1);
        check("clear_amask", auto_mask, 64'd0);
        run_window(6, 1'b0, 49, h, r);
        check("clrset_prev_rate", {32'd0, r}, 64'd1);
        check("clrset_hits", 64'(h), 64'd6);
        check("clrset_amask", auto_mask, 64'd0);
        run_window(6, 1'b0, 0, h, r);
        check("reeval_rate", {32'd0, r}, 64'd6);
        check("reeval_amask", auto_mask, 64'h1);

        // Reset in the middle of traffic, then a fresh 100-tick window on ch63.
        @(posedge clk_adc);
        #1 coax_in[63] = 1'b0;
        @(negedge clk_adc);
        check("pre_reset_rate", {32'd0, rate_out}, 64'd6);
        #2 nrst = 1'b0;
        #1;
        check("mid_reset_hits", coax_hits, 64'd0);
        check("mid_reset_amask", auto_mask, 64'd0);
        check("mid_reset_rate", {32'd0, rate_out}, 64'd0);
        check("mid_reset_wdone", {63'd0, window_done}, 64'd0);
        @(posedge clk_adc);
        @(posedge clk_adc);
        #1;
        nrst     = 1'b1;
        win_len  = 24'd100;
        rate_sel = 6'd63;
        pulses   = 0;
        for (int k = 1; k <= 102; k++) begin
            @(posedge clk_adc);
            #1 coax_in[63] = !((k < 28) && (k % 4 < 2));
            @(negedge clk_adc);
            if (coax_hits[63]) pulses++;
            if (k == LAT - 1) check("post_reset_early", coax_hits, 64'd0);
            if (k == LAT)     check("post_reset_hit", coax_hits, 64'h8000_0000_0000_0000);
            if (k == 99)      check("win100_not_yet", {63'd0, window_done}, 64'd0);
            if (k == 100) begin
                check("win100_end", {63'd0, window_done}, 64'd1);
                check("rate63_stale", {32'd0, rate_out}, 64'd0);
            end
            if (k == 101) begin
                check("rate63", {32'd0, rate_out}, 64'd7);
                check("win100_pulse_len", {63'd0, window_done}, 64'd0);
            end
        end
        check("ch63_pulses", 64'(pulses), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
